// File: rtl/slice_serial_adder.sv
// rtl/slice_serial_adder.sv - word-serial sequencer feeding a combinational SLICE-bit adder, LSB chunk first
module slice_serial_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic [SLICE-1:0] slice_a,
    output logic [SLICE-1:0] slice_b,
    output logic             slice_cin,
    input  logic [SLICE-1:0] slice_s,
    input  logic             slice_cout,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_reg, b_reg, sum_r;
    logic              carry, cout_r;
    logic              last;

    assign last = (idx == IDXW'(NSLICE - 1));
    assign sum  = sum_r;
    assign cout = cout_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b1;
        slice_a     = '0;
        slice_b     = '0;
        slice_cin   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) state_nxt = RUN;
            end
            RUN: begin
                slice_a   = a_reg[idx*SLICE +: SLICE];
                slice_b   = b_reg[idx*SLICE +: SLICE];
                slice_cin = carry;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sum is deliberately left alone on accept; it is rebuilt chunk by chunk during RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_r[idx*SLICE +: SLICE] <= slice_s;
                    carry <= slice_cout;
                    if (last) begin
                        cout_r <= slice_cout;
                        idx    <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/slice_serial_adder.md
Name: slice_serial_adder

Overview:
- Word-serial sequencer that sits directly upstream of the 4-bit ripple-carry slice adder.
- Accepts one WIDTH-bit add request, splits both operands into SLICE-bit chunks, and feeds them to the slice adder one chunk per clock, LSB chunk first.
- Carries the slice carry-out between cycles, assembles the full sum, and presents it on a valid/ready result interface.
- Lets the team build 16/32-bit adds from the existing combinational slice.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be an integer multiple of SLICE and at least SLICE.
- SLICE, 4, slice adder width in bits. Must match the attached slice adder.
- NSLICE is derived as WIDTH/SLICE (local, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  request present
- start_ready  output  1  block can accept a request
- op_a  input  WIDTH  operand A, sampled on accept
- op_b  input  WIDTH  operand B, sampled on accept
- cin  input  1  carry-in of the whole add, sampled on accept
- slice_a  output  SLICE  current chunk of A to slice adder
- slice_b  output  SLICE  current chunk of B to slice adder
- slice_cin  output  1  carry into current slice
- slice_s  input  SLICE  slice adder sum (combinational return)
- slice_cout  input  1  slice adder carry-out (combinational return)
- sum  output  WIDTH  assembled result
- cout  output  1  final carry-out
- done_valid  output  1  result available
- done_ready  input  1  consumer takes result
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry reg=0, operand regs=0, sum=0, cout=0, done_valid=0, busy=0.
  - start_ready goes to 1 while in IDLE. The async reset does not wait for an edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1, latch op_a, op_b, cin into the operand and carry regs, set idx=0, and go to RUN.
  - The sum register is not cleared on accept.
- RUN:
  - start_ready=0.
  - slice_a = A_reg[idx*SLICE +: SLICE]. slice_b = B_reg[idx*SLICE +: SLICE]. slice_cin = carry reg.
  - On each edge: sum[idx*SLICE +: SLICE] <= slice_s; carry <= slice_cout; idx <= idx+1.
  - On the edge where idx==NSLICE-1: cout <= slice_cout, go to DONE, idx <= 0.
- DONE:
  - done_valid=1. sum and cout are held stable.
  - On an edge with done_ready=1, go to IDLE and drop done_valid.
  - done_ready is ignored outside DONE.
- Slice outputs: slice_a, slice_b and slice_cin are driven 0 in IDLE and DONE.
- Latency:
  - Request accepted at edge k; RUN occupies edges k+1 .. k+NSLICE.
  - done_valid is high from edge k+NSLICE.
  - For the defaults (NSLICE=4), the result is visible 4 cycles after accept.
- No overlap: a new request is accepted only in IDLE, so the minimum spacing between accepts is NSLICE+2 cycles (when done_ready is held high).
- start_valid during RUN or DONE is not accepted and not stored. The requester must hold it until start_ready.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1). This assumes a correct slice adder. Operands are unsigned; no overflow flag.
- Slice return path: slice_s and slice_cout are combinational within the same cycle; no registering inside the slice adder is expected.
- Reset mid-RUN or mid-DONE: abort immediately and return to reset values. The partial sum is discarded (sum=0).
- busy = (state != IDLE).

Test Plan:
- WIDTH=16, op_a=0x1234, op_b=0x4321, cin=0, done_ready=1 -> after 4 RUN cycles sum=0x5555, cout=0, done_valid for 1 cycle, then start_ready=1.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> carry ripples through all four slices. slice_cin sequence is 0,1,1,1; result sum=0x0000, cout=1.
- op_a=0x0000, op_b=0x0000, cin=1 -> first slice_cin=1; sum=0x0001, cout=0. Then op_a=0x8000, op_b=0x8000, cin=0 -> sum=0x0000, cout=1.
- Backpressure: done_ready=0 for 5 cycles after done_valid -> sum/cout/done_valid held stable, start_ready=0. A new start_valid with op_a=0x1111 pulsed during DONE is not accepted. Then done_ready=1 -> IDLE.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles of 0x00FF+0x0001 -> immediately busy=0, sum=0, done_valid=0. After release, 0x0006+0x0004 gives sum=0x000A.
- Randomized sweep: 200 random op_a/op_b/cin with random done_ready stalls -> every {cout,sum} equals op_a+op_b+cin. The bench models the slice adder behaviourally (4-bit + with carry).
